// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences one read/write request into precharge, word-line, write-drive and sense phases of a 6T SRAM array.
// Optional macro SRAM_CTRL_WRITE_VERIFY_EN adds a read-back pass after every write and reports mismatches on verify_err.
module sram_ctrl #(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int PRE_CYC = 1,
    parameter int WL_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [AW-1:0]       req_addr,
    input  logic [DW-1:0]       req_wdata,
    output logic                rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                verify_err,
    output logic                pre_en,
    output logic [(2**AW)-1:0]  wl,
    output logic                bl_drv_en,
    output logic [DW-1:0]       bl_wdata,
    output logic                sae,
    input  logic [DW-1:0]       sa_data
);
    localparam int ROWS    = 2 ** AW;
    localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] PRE_LOAD = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] WL_LOAD  = CW'(WL_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_ACC  = 2'd2,
        S_REC  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            last_cyc;
    logic            read_pass;
    logic            drive;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, so inputs are don't-care otherwise.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign last_cyc  = (cnt_q == '0);

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    logic vpass_q, vpass_d;
    logic verr_q, verr_d;

    assign read_pass = !we_q || vpass_q;
    assign drive     = (state_q == S_ACC) && we_q && !vpass_q;
`else
    assign read_pass = !we_q;
    assign drive     = (state_q == S_ACC) && we_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        vpass_d = vpass_q;
        verr_d  = verr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = PRE_LOAD;
                    state_d = S_PRE;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
                    vpass_d = 1'b0;
                    verr_d  = 1'b0;
`endif
                end
            end
            S_PRE: begin
                if (last_cyc) begin
                    cnt_d   = WL_LOAD;
                    state_d = S_ACC;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACC: begin
                if (last_cyc) begin
                    // Sense amps resolve during the sae cycle; capture on the edge that ends it.
                    if (read_pass) begin
                        rdata_d = sa_data;
                    end
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
                    if (we_q && !vpass_q) begin
                        vpass_d = 1'b1;
                        cnt_d   = PRE_LOAD;
                        state_d = S_PRE;
                    end else begin
                        if (vpass_q) begin
                            verr_d = (sa_data != wdata_q);
                        end
                        cnt_d   = '0;
                        state_d = S_REC;
                    end
`else
                    cnt_d   = '0;
                    state_d = S_REC;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_REC: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pre_en    = (state_q == S_PRE);
        wl        = '0;
        if (state_q == S_ACC) begin
            wl[addr_q] = 1'b1;
        end
        bl_drv_en = drive;
        bl_wdata  = drive ? wdata_q : '0;
        sae       = (state_q == S_ACC) && read_pass && last_cyc;
        rsp_valid = (state_q == S_REC);
        rsp_rdata = rdata_q;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        verify_err = (state_q == S_REC) && verr_q;
`else
        verify_err = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            vpass_q <= 1'b0;
            verr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            vpass_q <= vpass_d;
            verr_q  <= verr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default instance against a behavioural array/reference model plus a PRE_CYC=3, WL_CYC=1 instance.
// Build with SRAM_CTRL_WRITE_VERIFY_EN defined to exercise the write read-back pass.
`timescale 1ns/1ps
module tb_sram_ctrl;
    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int ROWS   = 16;
    localparam int PRE    = 1;
    localparam int WLC    = 2;
    localparam int SW_PRE = 3;
    localparam int SW_WL  = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clear = 1'b1;
    always #5 clk = ~clk;

    // ---------------- default DUT ----------------
    logic            req_valid, req_we, req_ready, rsp_valid, verify_err;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata, rsp_rdata, bl_wdata, sa_data;
    logic            pre_en, bl_drv_en, sae;
    logic [ROWS-1:0] wl;

    sram_ctrl #(.AW(AW), .DW(DW), .PRE_CYC(PRE), .WL_CYC(WLC)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .verify_err(verify_err),
        .pre_en(pre_en), .wl(wl), .bl_drv_en(bl_drv_en), .bl_wdata(bl_wdata),
        .sae(sae), .sa_data(sa_data)
    );

    // ---------------- sweep DUT ----------------
    logic            sw_req_valid, sw_req_we, sw_req_ready, sw_rsp_valid, sw_verify_err;
    logic [AW-1:0]   sw_req_addr;
    logic [DW-1:0]   sw_req_wdata, sw_rsp_rdata, sw_bl_wdata, sw_sa_data;
    logic            sw_pre_en, sw_bl_drv_en, sw_sae;
    logic [ROWS-1:0] sw_wl;

    sram_ctrl #(.AW(AW), .DW(DW), .PRE_CYC(SW_PRE), .WL_CYC(SW_WL)) u_sw (
        .clk(clk), .rst(rst),
        .req_valid(sw_req_valid), .req_ready(sw_req_ready), .req_we(sw_req_we),
        .req_addr(sw_req_addr), .req_wdata(sw_req_wdata),
        .rsp_valid(sw_rsp_valid), .rsp_rdata(sw_rsp_rdata), .verify_err(sw_verify_err),
        .pre_en(sw_pre_en), .wl(sw_wl), .bl_drv_en(sw_bl_drv_en), .bl_wdata(sw_bl_wdata),
        .sae(sw_sae), .sa_data(sw_sa_data)
    );

    assign sw_sa_data = sw_sae ? 8'h5A : 8'h00;

    // ---------------- bitcell array model ----------------
    logic [DW-1:0] cells [ROWS];
    logic          stuck_bit0 = 1'b0;

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (mem_clear) cells[r] <= '0;
            else if (bl_drv_en && wl[r]) cells[r] <= bl_wdata;
        end
    end

    always_comb begin
        sa_data = '0;
        if (sae) begin
            for (int r = 0; r < ROWS; r++) begin
                if (wl[r]) sa_data = cells[r] | {7'b0, stuck_bit0};
            end
        end
    end

    // ---------------- scoreboard / reference ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] exp_mem [ROWS];
    logic [DW-1:0] last_rd;
    int acc_q[$];
    int rsp_cnt = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (rsp_valid) rsp_cnt++;
        if (!rst) begin
            check("invariants", {63'b0,
                  !(pre_en && |wl) && !(bl_drv_en && !(|wl)) && !(sae && bl_drv_en) &&
                  ($countones(wl) <= 1) && !(rsp_valid && req_ready)}, 64'd1);
            check("sw_invariants", {63'b0,
                  !(sw_pre_en && |sw_wl) && !(sw_bl_drv_en && !(|sw_wl)) &&
                  !(sw_sae && sw_bl_drv_en) && ($countones(sw_wl) <= 1)}, 64'd1);
        end
    end

    function automatic int latency(input logic we);
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        if (we) return 2 * (PRE + WLC) + 1;
`endif
        return PRE + WLC + 1;
    endfunction

    // Expected {req_ready, pre_en, wl, bl_drv_en, sae, rsp_valid} in cycle k after the handshake edge.
    function automatic logic [20:0] exp_vec(input int k, input logic we, input logic [AW-1:0] a);
        logic p, d, s, r, vp;
        logic [ROWS-1:0] w;
        int kk;
        p = 0; d = 0; s = 0; r = 0; vp = 0; w = '0; kk = k;
        if (k == latency(we)) begin
            r = 1;
        end else begin
            if (we && kk > PRE + WLC) begin
                kk = kk - (PRE + WLC);
                vp = 1;
            end
            if (kk <= PRE) p = 1;
            else begin
                w = ROWS'(1) << a;
                d = we && !vp;
                s = (!we || vp) && (kk == PRE + WLC);
            end
        end
        return {1'b0, p, w, d, s, r};
    endfunction

    // ---------------- driver ----------------
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int lat, n;
        logic exp_verr;
        lat = latency(we);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("req_ready_timeout", {63'b0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = $urandom_range(0, 1); req_we = $urandom_range(0, 1);
        req_addr = AW'($urandom); req_wdata = DW'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("phase", {35'b0, req_ready, pre_en, wl, bl_drv_en, sae, rsp_valid,
                            (exp_vec(k, we, a)[2] ? bl_wdata : 8'h00)},
                           {35'b0, exp_vec(k, we, a), (exp_vec(k, we, a)[2] ? wd : 8'h00)});
            if (k < lat) begin
                @(posedge clk); #1;
                if (k + 1 == lat) req_valid = 0;
                else begin
                    req_valid = $urandom_range(0, 1); req_addr = AW'($urandom);
                    req_wdata = DW'($urandom); req_we = $urandom_range(0, 1);
                end
            end
        end
        exp_verr = 1'b0;
        if (!we) last_rd = exp_mem[a];
        else begin
            exp_mem[a] = wd;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            last_rd  = wd | {7'b0, stuck_bit0};
            exp_verr = stuck_bit0 && !wd[0];
`endif
        end
        check("rsp_rdata", {56'b0, rsp_rdata}, {56'b0, last_rd});
        check("verify_err", {63'b0, verify_err}, {63'b0, exp_verr});
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t tbl [9];

    initial begin
        int n, gap;
        tbl[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
        tbl[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
        tbl[2] = '{1'b1, 4'd0,  8'hFF, 8'h00};
        tbl[3] = '{1'b1, 4'd15, 8'h5A, 8'h00};
        tbl[4] = '{1'b0, 4'd0,  8'h00, 8'hFF};
        tbl[5] = '{1'b0, 4'd15, 8'h00, 8'h5A};
        tbl[6] = '{1'b1, 4'd3,  8'h3C, 8'h00};
        tbl[7] = '{1'b0, 4'd3,  8'h00, 8'h3C};
        tbl[8] = '{1'b0, 4'd7,  8'h00, 8'h00};
        for (int r = 0; r < ROWS; r++) exp_mem[r] = '0;
        last_rd = '0;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        sw_req_valid = 0; sw_req_we = 0; sw_req_addr = '0; sw_req_wdata = '0;

        // reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_outputs", {35'b0, req_ready, pre_en, wl, bl_drv_en, sae, rsp_valid, verify_err,
                                rsp_rdata}, 64'd0);
        check("reset_bl_wdata", {56'b0, bl_wdata}, 64'd0);
        @(posedge clk); #1;
        rst = 0; mem_clear = 0;

        // abort a write in ACC with a 2-cycle reset
        req_valid = 1; req_we = 1; req_addr = 4'd5; req_wdata = 8'h00;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_in_acc_wl", {48'b0, wl}, 64'h0020);
        n = rsp_cnt;
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_controls", {42'b0, req_ready, pre_en, wl, bl_drv_en, sae, rsp_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("ready_after_reset", {63'b0, req_ready}, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_cnt, n);

        // sweep instance: read at N -> sae and wl together at N+4, rsp at N+5
        sw_req_valid = 1; sw_req_we = 0; sw_req_addr = 4'd2;
        @(negedge clk);
        check("sw_ready", {63'b0, sw_req_ready}, 64'd1);
        @(posedge clk); #1;
        sw_req_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("sw_phase", {43'b0, sw_pre_en, sw_wl, sw_sae, sw_bl_drv_en, sw_rsp_valid},
                  {43'b0, (k <= 3), (k == 4 ? 16'h0004 : 16'h0000), (k == 4), 1'b0, (k == 5)});
            if (k < 5) begin @(posedge clk); #1; end
        end
        check("sw_rdata", {56'b0, sw_rsp_rdata}, 64'h5A);
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 9; i++) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].we) check("table_rdata", {56'b0, rsp_rdata}, {56'b0, tbl[i].exp_rdata});
        end

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        // stuck-at-1 bit 0: read-back must flag the write of 0x3C
        stuck_bit0 = 1;
        do_req(1'b1, 4'd9, 8'h3C);
        check("verify_stuck_rdata", {56'b0, rsp_rdata}, 64'h3D);
        stuck_bit0 = 0;
`endif

        // back-to-back accepts with req_valid held high
        acc_q.delete();
        n = rsp_cnt;
        req_valid = 1; req_we = 0; req_addr = 4'd3;
        gap = 0;
        while (acc_q.size() < 4 && gap < 100) begin
            @(posedge clk); #1;
            gap++;
        end
        req_valid = 0;
        check("b2b_accepts", acc_q.size(), 4);
        for (int i = 1; i < acc_q.size(); i++) check("b2b_spacing", acc_q[i] - acc_q[i-1], 5);
        repeat (6) @(posedge clk);
        #1;
        check("b2b_rsp_count", rsp_cnt - n, 4);
        last_rd = exp_mem[3];
        check("b2b_rdata", {56'b0, rsp_rdata}, {56'b0, last_rd});

        // random traffic against the reference model
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            do_req($urandom_range(0, 1), AW'($urandom), DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
